// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped dynamic branch predictor for the five-stage MIPS pipeline.
// Fetch queries the table with its PC and gets a zero-latency taken guess
// plus a target. The D stage reports each resolved branch back. The table
// is trained on that outcome, and a mispredict is flagged when the guess
// was wrong. Two saturating counters track branches and mispredictions for
// performance evaluation.
//
// Each entry holds a valid bit, a tag, a 2-bit saturating counter and a
// 32-bit target. The entry index is PC[IDX_W+1:2], the tag is the rest of
// the PC above the index, and PC[1:0] is ignored.
//
// Ports:
//   clk              in   1   system clock, rising edge
//   reset            in   1   asynchronous active-high reset
//   F_PC             in  32   fetch-stage PC to predict
//   pred_taken       out  1   predicted taken for F_PC
//   pred_target      out 32   predicted target for F_PC (0 on a miss)
//   upd_valid        in   1   a branch resolved in D this cycle
//   upd_PC           in  32   PC of the resolved branch
//   upd_taken        in   1   resolved outcome
//   upd_target       in  32   resolved branch target
//   upd_pred_taken   in   1   prediction made for this branch in F
//   upd_pred_target  in  32   target predicted for this branch in F
//   mispredict       out  1   resolved branch disagrees with its prediction
//   branch_cnt       out 32   resolved branches (saturating)
//   miss_cnt         out 32   mispredictions (saturating)
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] F_PC,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_PC,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] branch_cnt,
    output logic [31:0] miss_cnt
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 32 - IDX_W - 2;

    logic               valid_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];

    logic [31:0]        branchCnt_q, branchCnt_d;
    logic [31:0]        missCnt_q,   missCnt_d;

    logic [IDX_W-1:0]   fIdx, uIdx;
    logic [TAG_W-1:0]   fTag, uTag;
    logic               fHit, uHit;

    logic [1:0]         ctr_d;
    logic [31:0]        target_d;

    assign fIdx = F_PC[IDX_W+1:2];
    assign fTag = F_PC[31:IDX_W+2];
    assign uIdx = upd_PC[IDX_W+1:2];
    assign uTag = upd_PC[31:IDX_W+2];

    // Lookup for fetch. There is no bypass from the update port. A query
    // that targets the entry being written this cycle sees the old contents.
    // Reset clears every valid bit asynchronously, so the prediction reads 0
    // during reset and right after it without extra gating.
    assign fHit        = valid_q[fIdx] && (tag_q[fIdx] == fTag);
    assign pred_taken  = fHit && ctr_q[fIdx][1];
    assign pred_target = fHit ? target_q[fIdx] : 32'd0;

    assign uHit = valid_q[uIdx] && (tag_q[uIdx] == uTag);

    // A taken branch must also have gone to the predicted target. The target
    // of a not-taken branch is irrelevant to the fetch stream.
    assign mispredict = upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));

    // New counter and target for the entry addressed by the update.
    // On a hit, the counter moves one step toward the outcome and saturates
    // at 00 and 11. The target is only refreshed when the branch is taken.
    // On a miss (invalid entry or foreign tag), the entry is reallocated to
    // this branch. It starts weakly taken with the resolved target, or at
    // the reset value with a zero target.
    always_comb begin
        ctr_d    = CTR_INIT;
        target_d = 32'd0;
        if (uHit) begin
            ctr_d    = ctr_q[uIdx];
            target_d = target_q[uIdx];
            if (upd_taken) begin
                target_d = upd_target;
                if (ctr_q[uIdx] != 2'b11) begin
                    ctr_d = ctr_q[uIdx] + 2'b01;
                end
            end else if (ctr_q[uIdx] != 2'b00) begin
                ctr_d = ctr_q[uIdx] - 2'b01;
            end
        end else if (upd_taken) begin
            ctr_d    = 2'b10;
            target_d = upd_target;
        end
    end

    // Statistics counters stick at all-ones instead of wrapping, so a long
    // run never reports a deceptively small count.
    always_comb begin
        branchCnt_d = branchCnt_q;
        missCnt_d   = missCnt_q;
        if (upd_valid && (branchCnt_q != 32'hFFFF_FFFF)) begin
            branchCnt_d = branchCnt_q + 32'd1;
        end
        if (mispredict && (missCnt_q != 32'hFFFF_FFFF)) begin
            missCnt_d = missCnt_q + 32'd1;
        end
    end

    // Table storage. Reset wipes every entry asynchronously, which also
    // drops any update presented in the same cycle. Without upd_valid,
    // nothing in the table changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                ctr_q[i]    <= CTR_INIT;
                target_q[i] <= 32'd0;
            end
        end else if (upd_valid) begin
            valid_q[uIdx]  <= 1'b1;
            tag_q[uIdx]    <= uTag;
            ctr_q[uIdx]    <= ctr_d;
            target_q[uIdx] <= target_d;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branchCnt_q <= 32'd0;
            missCnt_q   <= 32'd0;
        end else begin
            branchCnt_q <= branchCnt_d;
            missCnt_q   <= missCnt_d;
        end
    end

    assign branch_cnt = branchCnt_q;
    assign miss_cnt   = missCnt_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the five-stage MIPS pipeline, and the counterpart of the D-stage branch comparator.
- Fetch queries it with the F-stage PC and gets a taken/not-taken guess plus a target.
- The D stage reports the resolved comparator outcome back, and the block trains its tables on that outcome and flags mispredictions.
- It also keeps branch and mispredict statistics counters for performance evaluation.

Parameters:
- IDX_W, 6, index width; the table has 2^IDX_W entries indexed by PC[IDX_W+1:2].
- CTR_INIT, 2'b01, reset and allocate-on-not-taken value of each 2-bit counter (weakly not-taken).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- F_PC  input  32  fetch-stage PC to predict.
- pred_taken  output  1  predicted taken for F_PC.
- pred_target  output  32  predicted target for F_PC.
- upd_valid  input  1  a branch resolved in D this cycle.
- upd_PC  input  32  PC of the resolved branch.
- upd_taken  input  1  resolved outcome (comparator output).
- upd_target  input  32  resolved branch target.
- upd_pred_taken  input  1  prediction that was made for this branch, piped from F.
- upd_pred_target  input  32  target that was predicted, piped from F.
- mispredict  output  1  resolved branch disagrees with its prediction.
- branch_cnt  output  32  number of resolved branches.
- miss_cnt  output  32  number of mispredictions.

Behaviour:
- Field split: idx = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2]; PC[1:0] ignored.
- Per entry: valid (1 bit), tag, 2-bit counter ctr, 32-bit target.
- Reset (async, active-high):
  - All valid = 0, ctr = CTR_INIT, target = 0, tag = 0, branch_cnt = 0, miss_cnt = 0.
  - pred_taken = 0 and pred_target = 0 while reset is asserted and immediately after.
  - Reset asserted mid-update discards that update.
- Prediction (combinational, zero latency):
  - hit = valid[idx] && tag[idx] == tag(F_PC).
  - pred_taken = hit && ctr[idx][1].
  - pred_target = hit ? target[idx] : 0.
- Mispredict (combinational): mispredict = upd_valid && ((upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target)). It is 0 whenever upd_valid = 0.
- Update at the rising clk edge when upd_valid = 1 (u = upd_PC fields):
  - Hit on entry u.idx: ctr saturates upward on taken (11 stays 11) and downward on not-taken (00 stays 00). On taken, target <= upd_target; on not-taken, target is unchanged.
  - Miss, including an invalid entry or a tag mismatch: replace the entry with valid = 1, tag = u.tag, ctr = upd_taken ? 2'b10 : CTR_INIT, target = upd_taken ? upd_target : 0.
- Statistics:
  - branch_cnt += 1 on each edge with upd_valid.
  - miss_cnt += 1 on each edge with mispredict.
  - Both counters saturate at 32'hFFFF_FFFF; they do not wrap.
- Simultaneous read and update of the same idx: there is no bypass. The F-stage query sees pre-edge table contents, and the new value is visible from the next cycle.
- upd_valid = 0: no table or counter changes.
- Stalls are handled by the pipeline: it holds upd_valid low for bubbles and repeated D-stage cycles, so each branch updates exactly once.

Test Plan:
- Reset, then F_PC = 0x0000_3000 -> pred_taken = 0, pred_target = 0. Assert reset mid-run -> all tables and counters cleared asynchronously, before the next edge.
- First taken update: upd_PC = 0x3000, upd_taken = 1, upd_target = 0x3040, upd_pred_taken = 0.
  - Same cycle: mispredict = 1.
  - Next cycle, F_PC = 0x3000: pred_taken = 1, pred_target = 0x3040.
  - branch_cnt = 1, miss_cnt = 1.
- Saturation: 4 further taken updates to 0x3000, then 1 not-taken -> still predicted taken (ctr 11 -> 10). A second not-taken -> pred_taken = 0 (ctr 01).
- Aliasing: update 0x3000 taken, then 0x3100 not-taken (same idx with IDX_W = 6, different tag) -> query 0x3000 gives hit = 0, pred_taken = 0, pred_target = 0. Query 0x3100 gives hit with ctr = 01, pred_taken = 0.
- Same-cycle read/update: F_PC = upd_PC = 0x3200 with upd_taken = 1 on a cold entry -> pred_taken = 0 in that cycle, 1 in the next.
- Target mismatch: upd_pred_taken = 1, upd_taken = 1, upd_pred_target = 0x3040, upd_target = 0x3080 -> mispredict = 1 and the entry target becomes 0x3080. With upd_valid = 0 and the same other inputs -> mispredict = 0 and the counters do not change.
